// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcode and state definitions for the sequential ALU.
`timescale 1ns/1ps
package alu_pkg;

  localparam int OP_W = 4;

  typedef enum logic [OP_W-1:0] {
    OP_MV  = 4'd0,
    OP_ADD = 4'd1,
    OP_SUB = 4'd2,
    OP_AND = 4'd3,
    OP_OR  = 4'd4,
    OP_XOR = 4'd5,
    OP_SHL = 4'd6,
    OP_SHR = 4'd7,
    OP_MUL = 4'd8
  } op_t;

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_MUL_RUN = 1'b1
  } state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// rtl/alu_mul_seq.sv - shift-add multiplier, one multiplier bit per cycle.
`timescale 1ns/1ps
module alu_mul_seq #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic               busy;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;

  // product is the accumulator including the current iteration, so it is final in the done cycle
  assign product = acc + (mplier[0] ? mcand : '0);
  assign done    = busy && (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy   <= 1'b0;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (start) begin
      busy   <= 1'b1;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= {{WIDTH{1'b0}}, a};
      mplier <= b;
    end else if (busy) begin
      acc    <= product;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
      if (done) begin
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - sequential ALU top: request handshake, FSM, output register and flags.
`timescale 1ns/1ps
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             cFlag,
  output logic             zFlag,
  output logic             nFlag,
  output logic             vFlag
);

  localparam int SW = $clog2(WIDTH);

  state_t             state;
  logic               accept;
  logic               mul_start;
  logic               mul_done;
  logic [2*WIDTH-1:0] product;
  logic [WIDTH-1:0]   mul_lo;
  logic               mul_ovf;

  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     diff;
  logic [WIDTH:0]     shl_ext;
  logic [WIDTH:0]     shr_ext;
  logic [WIDTH-1:0]   res;
  logic               c_nxt;
  logic               v_nxt;
  logic               upd_zn;

  assign in_ready  = (state == ST_IDLE) && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign mul_start = accept && (op == OP_MUL);
  assign mul_lo    = product[WIDTH-1:0];
  assign mul_ovf   = |product[2*WIDTH-1:WIDTH];

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start),
    .a       (in1),
    .b       (in2),
    .done    (mul_done),
    .product (product)
  );

  // The extra bit on each shift extension catches the last bit shifted out (0 for amount 0)
  always_comb begin
    sum     = {1'b0, in1} + {1'b0, in2};
    diff    = {1'b0, in1} - {1'b0, in2};
    shl_ext = {1'b0, in1} << in2[SW-1:0];
    shr_ext = {in1, 1'b0} >> in2[SW-1:0];
    res     = '0;
    c_nxt   = cFlag;
    v_nxt   = vFlag;
    upd_zn  = 1'b1;
    case (op)
      OP_MV: begin
        res    = in1;
        upd_zn = 1'b0;
      end
      OP_ADD: begin
        res   = sum[WIDTH-1:0];
        c_nxt = sum[WIDTH];
        v_nxt = (in1[WIDTH-1] == in2[WIDTH-1]) && (sum[WIDTH-1] != in1[WIDTH-1]);
      end
      OP_SUB: begin
        res   = diff[WIDTH-1:0];
        c_nxt = diff[WIDTH];
        v_nxt = (in1[WIDTH-1] != in2[WIDTH-1]) && (diff[WIDTH-1] != in1[WIDTH-1]);
      end
      OP_AND: res = in1 & in2;
      OP_OR:  res = in1 | in2;
      OP_XOR: res = in1 ^ in2;
      OP_SHL: begin
        res   = shl_ext[WIDTH-1:0];
        c_nxt = shl_ext[WIDTH];
      end
      OP_SHR: begin
        res   = shr_ext[WIDTH:1];
        c_nxt = shr_ext[0];
      end
      default: upd_zn = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      out       <= '0;
      out_valid <= 1'b0;
      cFlag     <= 1'b0;
      zFlag     <= 1'b0;
      nFlag     <= 1'b0;
      vFlag     <= 1'b0;
    end else begin
      if (accept && (op != OP_MUL)) begin
        out       <= res;
        out_valid <= 1'b1;
        cFlag     <= c_nxt;
        vFlag     <= v_nxt;
        if (upd_zn) begin
          zFlag <= (res == '0);
          nFlag <= res[WIDTH-1];
        end
      end else if ((state == ST_MUL_RUN) && mul_done) begin
        out       <= mul_lo;
        out_valid <= 1'b1;
        cFlag     <= mul_ovf;
        vFlag     <= mul_ovf;
        zFlag     <= (mul_lo == '0);
        nFlag     <= mul_lo[WIDTH-1];
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      case (state)
        ST_IDLE:    if (mul_start) state <= ST_MUL_RUN;
        ST_MUL_RUN: if (mul_done)  state <= ST_IDLE;
        default:    state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - directed self-checking bench for alu_seq at WIDTH=16.
`timescale 1ns/1ps
module tb_alu_seq;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b1;
  logic [3:0]   op = 4'd0;
  logic [W-1:0] in1 = '0;
  logic [W-1:0] in2 = '0;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] out;
  logic         cFlag, zFlag, nFlag, vFlag;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .in1       (in1),
    .in2       (in2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .cFlag     (cFlag),
    .zFlag     (zFlag),
    .nFlag     (nFlag),
    .vFlag     (vFlag)
  );

  // {out_valid, out, C, Z, N, V}
  function automatic logic [W+4:0] snap();
    return {out_valid, out, cFlag, zFlag, nFlag, vFlag};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    op = o; in1 = a; in2 = b; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    vectors++;
    if (snap() !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h want %h", snap(), 21'h0);
    end
    rst_n = 1'b1;
    step();
    vectors++;
    if ({in_ready, out_valid} !== 2'b10) begin
      miscompares++;
      $display("FAIL reset_ready: got %b want %b", {in_ready, out_valid}, 2'b10);
    end
  endtask

  task automatic test_add();
    issue(4'd1, 16'hFFFF, 16'h0001);
    vectors++;
    if (snap() !== {1'b1, 16'h0000, 4'b1100}) begin
      miscompares++;
      $display("FAIL add_wrap: got %h want %h", snap(), {1'b1, 16'h0000, 4'b1100});
    end
    step();
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL add_consumed: got %b want 0", out_valid);
    end
  endtask

  task automatic test_sub_mv();
    issue(4'd2, 16'h8000, 16'h0001);
    vectors++;
    if (snap() !== {1'b1, 16'h7FFF, 4'b0001}) begin
      miscompares++;
      $display("FAIL sub_ovf: got %h want %h", snap(), {1'b1, 16'h7FFF, 4'b0001});
    end
    issue(4'd0, 16'h1234, 16'hFFFF);
    vectors++;
    if (snap() !== {1'b1, 16'h1234, 4'b0001}) begin
      miscompares++;
      $display("FAIL mv_keep_flags: got %h want %h", snap(), {1'b1, 16'h1234, 4'b0001});
    end
  endtask

  task automatic test_logic();
    logic [3:0]   ops [3]  = '{4'd3, 4'd5, 4'd4};
    logic [W-1:0] a   [3]  = '{16'hF0F0, 16'hFFFF, 16'h0000};
    logic [W-1:0] b   [3]  = '{16'h0FF0, 16'h7FFF, 16'h0000};
    logic [W+4:0] exp [3]  = '{{1'b1, 16'h00F0, 4'b0001},
                               {1'b1, 16'h8000, 4'b0011},
                               {1'b1, 16'h0000, 4'b0101}};
    for (int i = 0; i < 3; i++) begin
      issue(ops[i], a[i], b[i]);
      vectors++;
      if (snap() !== exp[i]) begin
        miscompares++;
        $display("FAIL logic_op%0d: got %h want %h", ops[i], snap(), exp[i]);
      end
    end
  endtask

  task automatic test_shift_reserved();
    logic [3:0]   ops [5]  = '{4'd6, 4'd7, 4'd7, 4'd6, 4'd15};
    logic [W-1:0] a   [5]  = '{16'h8001, 16'h0003, 16'h0003, 16'h0001, 16'hFFFF};
    logic [W-1:0] b   [5]  = '{16'h0001, 16'h0000, 16'h0001, 16'h0011, 16'h1234};
    logic [W+4:0] exp [5]  = '{{1'b1, 16'h0002, 4'b1001},
                               {1'b1, 16'h0003, 4'b0001},
                               {1'b1, 16'h0001, 4'b1001},
                               {1'b1, 16'h0002, 4'b0001},
                               {1'b1, 16'h0000, 4'b0001}};
    for (int i = 0; i < 5; i++) begin
      issue(ops[i], a[i], b[i]);
      vectors++;
      if (snap() !== exp[i]) begin
        miscompares++;
        $display("FAIL shift_res_%0d: got %h want %h", i, snap(), exp[i]);
      end
    end
  endtask

  task automatic run_mul(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W+4:0] exp);
    logic [3:0] flags_before;
    flags_before = {cFlag, zFlag, nFlag, vFlag};
    issue(4'd8, a, b);
    for (int i = 1; i <= W; i++) begin
      vectors++;
      if ({in_ready, out_valid} !== 2'b00) begin
        miscompares++;
        $display("FAIL mul_busy_c%0d: got %b want 00", i, {in_ready, out_valid});
      end
      if (i == 8) begin
        vectors++;
        if ({cFlag, zFlag, nFlag, vFlag} !== flags_before) begin
          miscompares++;
          $display("FAIL mul_flags_hold: got %b want %b", {cFlag, zFlag, nFlag, vFlag}, flags_before);
        end
      end
      step();
    end
    vectors++;
    if ({in_ready, snap()} !== {1'b1, exp}) begin
      miscompares++;
      $display("FAIL mul_%h_%h: got %h want %h", a, b, {in_ready, snap()}, {1'b1, exp});
    end
  endtask

  task automatic test_mul();
    run_mul(16'h0100, 16'h0100, {1'b1, 16'h0000, 4'b1101});
    run_mul(16'h00FF, 16'h0101, {1'b1, 16'hFFFF, 4'b0010});
    run_mul(16'hFFFF, 16'hFFFF, {1'b1, 16'h0001, 4'b1001});
    step();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    issue(4'd1, 16'h0002, 16'h0003);
    op = 4'd5; in1 = 16'h00FF; in2 = 16'h0F0F; in_valid = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      vectors++;
      if ({in_ready, snap()} !== {1'b0, 1'b1, 16'h0005, 4'b0000}) begin
        miscompares++;
        $display("FAIL bp_hold_c%0d: got %h want %h", i, {in_ready, snap()}, {1'b0, 1'b1, 16'h0005, 4'b0000});
      end
      step();
    end
    out_ready = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_ready_rise: got %b want 1", in_ready);
    end
    step();
    in_valid = 1'b0;
    vectors++;
    if (snap() !== {1'b1, 16'h0FF0, 4'b0000}) begin
      miscompares++;
      $display("FAIL bp_next_op: got %h want %h", snap(), {1'b1, 16'h0FF0, 4'b0000});
    end
    step();
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_drain: got %b want 0", out_valid);
    end
  endtask

  task automatic test_reset_mid_mul();
    logic seen_valid;
    issue(4'd8, 16'hFFFF, 16'hFFFF);
    repeat (W) step();
    step();
    issue(4'd8, 16'h0100, 16'h0100);
    repeat (7) step();
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({in_ready, snap()} !== {1'b1, 21'h0}) begin
      miscompares++;
      $display("FAIL rst_mid_mul: got %h want %h", {in_ready, snap()}, {1'b1, 21'h0});
    end
    #2;
    rst_n = 1'b1;
    seen_valid = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (out_valid) seen_valid = 1'b1;
    end
    vectors++;
    if ({seen_valid, snap()} !== 22'h0) begin
      miscompares++;
      $display("FAIL rst_no_result: got %h want %h", {seen_valid, snap()}, 22'h0);
    end
    issue(4'd1, 16'h0001, 16'h0001);
    vectors++;
    if (snap() !== {1'b1, 16'h0002, 4'b0000}) begin
      miscompares++;
      $display("FAIL rst_then_add: got %h want %h", snap(), {1'b1, 16'h0002, 4'b0000});
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_mv();
    test_logic();
    test_shift_reserved();
    test_mul();
    test_back_to_back();
    test_reset_mid_mul();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter WIDTH, default 16, datapath width in bits (legal 8..64).
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  operation request present.
REQ-005 in_ready  output  1  block accepts request this cycle.
REQ-006 op  input  4  opcode: 0 MV, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 SHL, 7 SHR, 8 MUL; 9..15 reserved.
REQ-007 in1, in2  input  WIDTH each  operands.
REQ-008 out_valid  output  1  result held in output register.
REQ-009 out_ready  input  1  consumer takes result this cycle.
REQ-010 out  output  WIDTH  result.
REQ-011 cFlag, zFlag, nFlag, vFlag  output  1 each  registered carry, zero, negative, signed-overflow flags.

Function
REQ-012 Request accepted when in_valid && in_ready; operands and op captured on that edge.
REQ-013 in_ready = (state == IDLE) && (!out_valid || out_ready); combinational, no dependence on in_valid.
REQ-014 States IDLE, MUL_RUN; IDLE->MUL_RUN on accepted MUL; MUL_RUN->IDLE after WIDTH iteration cycles; all other ops stay IDLE.
REQ-015 Single-cycle ops: result and flags written to output register on accepting edge; out_valid high next cycle (latency 1).
REQ-016 MUL: shift-add, one multiplier bit per cycle; out_valid high WIDTH+1 cycles after acceptance; in_ready low throughout MUL_RUN.
REQ-017 out, flags and out_valid hold stable while out_valid && !out_ready; out_valid clears on out_ready unless a new result is written same edge.
REQ-018 ADD/SUB: computed at WIDTH+1 bits; cFlag = bit WIDTH (SUB: borrow, set when in1 < in2 unsigned); vFlag = signed overflow; zFlag, nFlag from out.
REQ-019 AND/OR/XOR: update zFlag, nFlag; cFlag, vFlag retain.
REQ-020 SHL/SHR: logical, amount = in2[clog2(WIDTH)-1:0]; cFlag = last bit shifted out, 0 for amount 0; zFlag, nFlag updated; vFlag retains.
REQ-021 MUL: out = low WIDTH bits of unsigned product; cFlag = vFlag = (high WIDTH bits != 0); zFlag, nFlag from out.
REQ-022 MV: out = in1; all flags retain.
REQ-023 Reserved opcode: accepted, out = 0, flags retain, out_valid asserted as for single-cycle op.
REQ-024 Flags change only when a result is written; never while held or during MUL_RUN.

Reset
REQ-025 rst_n low asynchronously forces state IDLE, out = 0, out_valid = 0, all four flags 0, MUL accumulator/counter 0.
REQ-026 Reset mid-MUL aborts operation; no result emitted after rst_n rises.
REQ-027 in_ready may be high in first cycle after rst_n deasserts.

Structure
REQ-028 Package alu_pkg holds opcode enum, state enum, and OP_W = 4.
REQ-029 Sub-module alu_mul_seq implements iterative multiplier (start, done, 2*WIDTH product); top holds FSM, output register, flag logic.

Verification
REQ-030 WIDTH=16: ADD 0xFFFF+0x0001 -> out 0x0000, C=1 Z=1 N=0 V=0, out_valid 1 cycle later.
REQ-031 SUB 0x8000-0x0001 -> out 0x7FFF, C=0 V=1 N=0 Z=0; then MV 0x1234 -> out 0x1234, flags unchanged.
REQ-032 MUL 0x0100*0x0100 -> in_ready low 16 cycles, out 0x0000, C=1 V=1 Z=1, out_valid at cycle 17.
REQ-033 SHL 0x8001 by 1 -> out 0x0002, C=1; SHR 0x0003 by 0 -> out 0x0003, C=0.
REQ-034 Backpressure: out_ready low 5 cycles after ADD 2+3 -> out 0x0005 held, in_ready low; back-to-back op accepted on cycle out_ready rises.
REQ-035 rst_n pulsed low at MUL iteration 8 -> out_valid never rises, all outputs 0, next ADD 1+1 -> 0x0002.
